// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Misaligned byte address or word index beyond the array is an error; indices never wrap.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        return addr[0] || ({17'd0, addr[ADDR_W-1:1]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array with synchronous write and synchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ARR_AW      = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ARR_AW-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Contents are deliberately not reset; rdata only moves on an enabled read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels with configurable wait states.
//
//  state  | meaning
//  S_IDLE | ready for a request; accepting latches it and loads the wait counter
//  S_WAIT | counting down wait states; access commits on the edge leaving this state
//  S_RESP | response held on rsp_* until rsp_ready, then back to S_IDLE
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned ARR_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic              rsp_sel;
    logic [WORD_W-1:0] arr_rdata;

    logic              accept;
    logic              go_resp;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [WORD_W-1:0] c_wdata;
    logic              c_err;
    logic              arr_en;

    // With zero wait states the commit happens on the accept edge, straight from the request inputs.
    always_comb begin
        accept  = (state == S_IDLE) && req_valid;
        go_resp = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd1));
        c_write = (state == S_IDLE) ? req_write : lat_write;
        c_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
        c_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
        c_err   = addr_err(c_addr, DEPTH_WORDS);
        arr_en  = go_resp && !c_err && !rst;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ARR_AW      (ARR_AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (c_write),
        .addr  (c_addr[ARR_AW:1]),
        .wdata (c_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_sel   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= c_err;
                            rsp_sel   <= !c_err && !c_write;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= c_err;
                        rsp_sel   <= !c_err && !c_write;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_sel   <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Load data lives in the array's read register, which only changes on a commit.
    assign rsp_rdata = rsp_sel ? arr_rdata : '0;

endmodule
